// File: rtl/wm_pkg.sv
// Shared types and constants for the washer controller: state encoding,
// output widths and the credit ceiling.
package wm_pkg;

    localparam int TIME_W     = 16;
    localparam int CREDIT_W   = 4;
    localparam int CREDIT_MAX = 15;

    // State codes are visible on the front panel, so the encoding is fixed.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WASH  = 3'd2,
        RINSE = 3'd3,
        SPIN  = 3'd4,
        DRAIN = 3'd5
    } wm_state_t;

    // Converts a duration given in seconds to the time_left register width.
    function automatic logic [TIME_W-1:0] secs_to_time(input int secs);
        return TIME_W'(secs);
    endfunction

endpackage : wm_pkg

// File: rtl/wm_if.sv
// Front-panel bundle between the washer controller and its environment.
// master: panel/sensor side (drives coins, buttons, loop selector).
// slave : controller side (drives state, countdown, credit, interlock).
interface wm_if;
    import wm_pkg::*;

    logic                coin_in;
    logic                start;
    logic [1:0]          extra_loops;
    logic                pause;
    wm_state_t           state_o;
    logic [TIME_W-1:0]   time_left;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                door_lock;
    logic                wash_done;

    modport master (
        output coin_in, start, extra_loops, pause,
        input  state_o, time_left, credit, busy, door_lock, wash_done
    );

    modport slave (
        input  coin_in, start, extra_loops, pause,
        output state_o, time_left, credit, busy, door_lock, wash_done
    );

endinterface : wm_if

// File: rtl/wm_tick_gen.sv
// One-second prescaler. Counts CLK_DIV cycles of the system clock and
// emits a single-cycle tick on the last count. clr restarts the second
// from zero (phase entry); hold freezes the count (pause).
module wm_tick_gen #(
    parameter int CLK_DIV = 16000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int              CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // A tick is only meaningful while the count is advancing.
    assign tick = !hold && (cnt == LAST);

    // Prescaler count: clear has priority, hold freezes, otherwise wrap at LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule : wm_tick_gen

// File: rtl/washing_machine_ctrl.sv
// Washer controller top: coin credit, start gating, phase sequencer with
// programmable extra wash/rinse loops, pause/resume and door interlock.
// Optional feature macro: WM_DRAIN_EN adds a DRAIN phase between the final
// RINSE and SPIN; without it the final RINSE goes straight to SPIN.
module washing_machine_ctrl
    import wm_pkg::*;
#(
    parameter int CLK_DIV   = 16000000,
    parameter int FILL_S    = 120,
    parameter int WASH_S    = 300,
    parameter int RINSE_S   = 120,
    parameter int SPIN_S    = 60,
    parameter int DRAIN_S   = 30,
    parameter int MAX_EXTRA = 3,
    parameter int PRICE     = 2
) (
    input  logic clk,
    input  logic rst,
    wm_if.slave  bus
);

    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] CREDIT_TOP = CREDIT_W'(CREDIT_MAX);

    wm_state_t           state;
    wm_state_t           nxt_state;
    logic [TIME_W-1:0]   time_left;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          loop_cnt;
    logic [1:0]          extra_lat;
    logic [1:0]          extra_sat;
    logic                busy;
    logic                wash_done;
    logic                coin_q;
    logic                coin_rise;
    logic                pause_q;
    logic                start_ok;
    logic                loop_again;
    logic                tick;
    logic                hold;
    logic                phase_end;
    logic                tick_clr;

    // Duration of each phase in seconds; IDLE has no countdown.
    function automatic logic [TIME_W-1:0] dur_of(input wm_state_t s);
        case (s)
            FILL:    return secs_to_time(FILL_S);
            WASH:    return secs_to_time(WASH_S);
            RINSE:   return secs_to_time(RINSE_S);
            SPIN:    return secs_to_time(SPIN_S);
            DRAIN:   return secs_to_time(DRAIN_S);
            default: return '0;
        endcase
    endfunction

    assign coin_rise = bus.coin_in && !coin_q;
    assign start_ok  = (state == IDLE) && bus.start && (credit >= PRICE_C);
    assign extra_sat = (int'(bus.extra_loops) > MAX_EXTRA) ? 2'(MAX_EXTRA)
                                                           : bus.extra_loops;

    // Pause acts one cycle after it is sampled, so a pause arriving on a
    // phase-ending edge lets that transition complete and freezes the new
    // phase at its full duration.
    assign hold      = pause_q && (state != IDLE);
    assign phase_end = tick && (state != IDLE) && (time_left == TIME_W'(1));
    assign tick_clr  = (state == IDLE) || phase_end;

    wm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (tick_clr),
        .hold (hold),
        .tick (tick)
    );

    // Coin edge detector, pause sampler and saturating credit counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            coin_q  <= 1'b0;
            pause_q <= 1'b0;
            credit  <= '0;
        end else begin
            coin_q  <= bus.coin_in;
            pause_q <= bus.pause;
            if (start_ok) begin
                // credit >= PRICE here, so the result never exceeds 14.
                credit <= credit - PRICE_C + {{(CREDIT_W-1){1'b0}}, coin_rise};
            end else if (coin_rise && (credit != CREDIT_TOP)) begin
                credit <= credit + 1'b1;
            end
        end
    end

    // Phase successor when the current phase runs out.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        nxt_state  = IDLE;
        loop_again = 1'b0;
        case (state)
            FILL:  nxt_state = WASH;
            WASH:  nxt_state = RINSE;
            RINSE: begin
                if (loop_cnt < extra_lat) begin
                    nxt_state  = WASH;
                    loop_again = 1'b1;
                end else begin
`ifdef WM_DRAIN_EN
                    nxt_state = DRAIN;
`else
                    nxt_state = SPIN;
`endif
                end
            end
`ifdef WM_DRAIN_EN
            DRAIN: nxt_state = SPIN;
`endif
            SPIN:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Main sequencer: start acceptance, per-second countdown, phase changes
    // and the registered panel outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            time_left <= '0;
            loop_cnt  <= '0;
            extra_lat <= '0;
            busy      <= 1'b0;
            wash_done <= 1'b0;
        end else begin
            wash_done <= 1'b0;
            if (state == IDLE) begin
                if (start_ok) begin
                    state     <= FILL;
                    time_left <= dur_of(FILL);
                    busy      <= 1'b1;
                    loop_cnt  <= '0;
                    extra_lat <= extra_sat;
                end
            end else if (tick) begin
                if (time_left > TIME_W'(1)) begin
                    time_left <= time_left - 1'b1;
                end else begin
                    state     <= nxt_state;
                    time_left <= dur_of(nxt_state);
                    busy      <= (nxt_state != IDLE);
                    if (loop_again) begin
                        loop_cnt <= loop_cnt + 1'b1;
                    end
                    if (nxt_state == IDLE) begin
                        wash_done <= 1'b1;
                        loop_cnt  <= '0;
                    end
                end
            end
        end
    end

    assign bus.state_o   = state;
    assign bus.time_left = time_left;
    assign bus.credit    = credit;
    assign bus.busy      = busy;
    assign bus.door_lock = busy;
    assign bus.wash_done = wash_done;

endmodule : washing_machine_ctrl
